// File: rtl/tone_tick_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tone_tick_gen
//  Description : Turns (period, duration) note commands into single-cycle
//                sin_clk step pulses for the 256-entry sine wavetable stage.
//                Each note plays for a fixed clock count, optionally followed
//                by a silent articulation gap.
//  Revision    : 1.0 - initial release
// ============================================================================
module tone_tick_gen #(
    parameter int PERIOD_W = 16,
    parameter int DUR_W    = 24,
    parameter int GAP_CYC  = 1024
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                note_valid,
    output logic                note_ready,
    input  logic [PERIOD_W-1:0] note_period,
    input  logic [DUR_W-1:0]    note_dur,
    input  logic                stop,
    output logic                sin_clk,
    output logic                playing,
    output logic                note_done
);

    localparam int               GAP_W      = (GAP_CYC > 0) ? $clog2(GAP_CYC + 1) : 1;
    localparam logic [GAP_W-1:0] C_GAP_LOAD = GAP_W'(GAP_CYC);
    localparam bit               C_GAP_EN   = (GAP_CYC > 0);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PLAY = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    state_t              r_state,   w_state_nxt;
    logic [PERIOD_W-1:0] r_period,  w_period_nxt;
    logic [PERIOD_W-1:0] r_per_cnt, w_per_nxt;
    logic [DUR_W-1:0]    r_dur_cnt, w_dur_nxt;
    logic [GAP_W-1:0]    r_gap_cnt, w_gap_nxt;
    logic                r_tick,    w_tick_nxt;
    logic                r_done,    w_done_nxt;
    logic                w_wrap;

    // Next-state, counter and look-ahead output logic for the note player
    always_comb begin
        w_state_nxt  = r_state;
        w_period_nxt = r_period;
        w_per_nxt    = r_per_cnt;
        w_dur_nxt    = r_dur_cnt;
        w_gap_nxt    = r_gap_cnt;
        w_done_nxt   = 1'b0;
        w_tick_nxt   = 1'b0;
        // Period 0 makes this compare against all-ones, which only matches on
        // the natural counter wrap, so the counter simply rolls over.
        w_wrap       = (r_per_cnt == (r_period - 1'b1));

        case (r_state)
            S_IDLE: begin
                if (note_valid) begin
                    w_period_nxt = note_period;
                    if (note_dur == '0) begin
                        w_done_nxt = 1'b1;
                    end else begin
                        w_state_nxt = S_PLAY;
                        w_per_nxt   = '0;
                        w_dur_nxt   = note_dur;
                    end
                end
            end
            S_PLAY: begin
                if (stop) begin
                    w_state_nxt = S_IDLE;
                    w_per_nxt   = '0;
                    w_dur_nxt   = '0;
                end else begin
                    w_per_nxt = w_wrap ? '0 : (r_per_cnt + 1'b1);
                    w_dur_nxt = r_dur_cnt - 1'b1;
                    if (r_dur_cnt == DUR_W'(1)) begin
                        w_per_nxt = '0;
                        if (C_GAP_EN) begin
                            w_state_nxt = S_GAP;
                            w_gap_nxt   = C_GAP_LOAD;
                        end else begin
                            w_state_nxt = S_IDLE;
                            w_done_nxt  = 1'b1;
                        end
                    end
                end
            end
            S_GAP: begin
                if (stop) begin
                    w_state_nxt = S_IDLE;
                    w_gap_nxt   = '0;
                end else begin
                    w_gap_nxt = r_gap_cnt - 1'b1;
                    if (r_gap_cnt == GAP_W'(1)) begin
                        w_state_nxt = S_IDLE;
                        w_done_nxt  = 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        // The pulse is decided one clock ahead so sin_clk comes from a flop
        // during the PLAY cycle whose period count reaches period-1.
        w_tick_nxt = (w_state_nxt == S_PLAY) && (w_period_nxt != '0) &&
                     (w_per_nxt == (w_period_nxt - 1'b1));
    end

    // State, counters and registered outputs; reset discards any latched note
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_period  <= '0;
            r_per_cnt <= '0;
            r_dur_cnt <= '0;
            r_gap_cnt <= '0;
            r_tick    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_period  <= w_period_nxt;
            r_per_cnt <= w_per_nxt;
            r_dur_cnt <= w_dur_nxt;
            r_gap_cnt <= w_gap_nxt;
            r_tick    <= w_tick_nxt;
            r_done    <= w_done_nxt;
        end
    end

    assign note_ready = (r_state == S_IDLE);
    assign playing    = (r_state == S_PLAY);
    assign note_done  = r_done;
    // stop suppresses a pulse in the very cycle it is asserted
    assign sin_clk    = r_tick & ~stop;

endmodule
`default_nettype wire

// File: tb/tb_tone_tick_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_tone_tick_gen
//  Description : Self-checking bench for tone_tick_gen. Two instances (no gap
//                and an 8-clock gap) share stimulus and are compared every
//                cycle against a note-level reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_tone_tick_gen;

    localparam int PW = 16;
    localparam int DW = 24;

    logic          clk         = 1'b0;
    logic          reset       = 1'b0;
    logic          note_valid  = 1'b0;
    logic          stop        = 1'b0;
    logic [PW-1:0] note_period = '0;
    logic [DW-1:0] note_dur    = '0;
    logic [1:0]    note_ready;
    logic [1:0]    sin_clk;
    logic [1:0]    playing;
    logic [1:0]    note_done;

    int errors = 0;
    int checks = 0;

    // Reference model state per instance: phase 0=idle 1=play 2=gap,
    // m_k = 1-based index of the current PLAY cycle.
    int c_gap [2] = '{0, 8};
    int m_ph  [2];
    int m_per [2];
    int m_dur [2];
    int m_k   [2];
    int m_gl  [2];
    bit m_done[2];

    always #5 clk = ~clk;

    tone_tick_gen #(.PERIOD_W(PW), .DUR_W(DW), .GAP_CYC(0)) u_dut0 (
        .clk(clk), .reset(reset), .note_valid(note_valid), .note_ready(note_ready[0]),
        .note_period(note_period), .note_dur(note_dur), .stop(stop),
        .sin_clk(sin_clk[0]), .playing(playing[0]), .note_done(note_done[0])
    );

    tone_tick_gen #(.PERIOD_W(PW), .DUR_W(DW), .GAP_CYC(8)) u_dut8 (
        .clk(clk), .reset(reset), .note_valid(note_valid), .note_ready(note_ready[1]),
        .note_period(note_period), .note_dur(note_dur), .stop(stop),
        .sin_clk(sin_clk[1]), .playing(playing[1]), .note_done(note_done[1])
    );

    function automatic logic [3:0] dut_out(input int i);
        return {note_ready[i], sin_clk[i], playing[i], note_done[i]};
    endfunction

    // Expected {ready, sin_clk, playing, note_done} in the current cycle
    function automatic logic [3:0] exp_out(input int i);
        logic tk;
        tk = 1'b0;
        if (m_ph[i] == 1 && m_per[i] != 0 && !stop)
            tk = ((m_k[i] % m_per[i]) == 0);
        return {m_ph[i] == 0, tk, m_ph[i] == 1, m_done[i]};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_ph[i] = 0; m_per[i] = 0; m_dur[i] = 0; m_k[i] = 0; m_gl[i] = 0; m_done[i] = 0;
        end
    endtask

    // Advance the model across one rising edge using the inputs held there
    task automatic model_adv();
        for (int i = 0; i < 2; i++) begin
            bit nd;
            nd = 0;
            case (m_ph[i])
                0: if (note_valid) begin
                    if (note_dur == '0) nd = 1;
                    else begin
                        m_ph[i] = 1; m_k[i] = 1;
                        m_per[i] = int'(note_period); m_dur[i] = int'(note_dur);
                    end
                end
                1: if (stop) m_ph[i] = 0;
                   else if (m_k[i] == m_dur[i]) begin
                       if (c_gap[i] > 0) begin m_ph[i] = 2; m_gl[i] = c_gap[i]; end
                       else begin m_ph[i] = 0; nd = 1; end
                   end else m_k[i]++;
                default: if (stop) m_ph[i] = 0;
                   else if (m_gl[i] == 1) begin m_ph[i] = 0; nd = 1; end
                   else m_gl[i]--;
            endcase
            m_done[i] = nd;
        end
    endtask

    task automatic clk_step();
        @(posedge clk);
        model_adv();
        #1;
    endtask

    task automatic test_reset();
        model_reset();
        reset = 1'b0; note_valid = 1'b1; note_period = 16'd3; note_dur = 24'd5;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (dut_out(i) !== 4'b1000) begin
                    errors++;
                    $display("FAIL reset_hold dut%0d c%0d: got %b want 1000", i, c, dut_out(i));
                end
            end
            @(posedge clk); #1;
        end
        @(negedge clk);
        reset = 1'b1; note_valid = 1'b0;
        clk_step();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (dut_out(i) !== exp_out(i)) begin
                    errors++;
                    $display("FAIL reset_release dut%0d c%0d: got %b want %b", i, c, dut_out(i), exp_out(i));
                end
            end
            clk_step();
        end
    endtask

    // One note accepted by both instances at cycle 0, then observed
    task automatic play_note(input string name, input int per, input int dur, input int ncyc);
        int pulses, plays, dones, exp_p;
        pulses = 0; plays = 0; dones = 0;
        note_period = PW'(per); note_dur = DW'(dur); note_valid = 1'b1; stop = 1'b0;
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (dut_out(i) !== exp_out(i)) begin
                    errors++;
                    $display("FAIL %s dut%0d c%0d: got %b want %b", name, i, c, dut_out(i), exp_out(i));
                end
            end
            if (sin_clk[0] === 1'b1)   pulses++;
            if (playing[0] === 1'b1)   plays++;
            if (note_done[0] === 1'b1) dones++;
            clk_step();
            note_valid = 1'b0;
        end
        exp_p = (per == 0) ? 0 : dur / per;
        checks++;
        if (pulses != exp_p) begin errors++; $display("FAIL %s_pulses: got %0d want %0d", name, pulses, exp_p); end
        checks++;
        if (plays != dur) begin errors++; $display("FAIL %s_play_len: got %0d want %0d", name, plays, dur); end
        checks++;
        if (dones != 1) begin errors++; $display("FAIL %s_done_cnt: got %0d want 1", name, dones); end
    endtask

    task automatic test_basic();
        play_note("basic", 4, 20, 32);
    endtask

    task automatic test_edges();
        play_note("per1", 1, 3, 15);
        play_note("rest", 0, 10, 22);
        play_note("dur0", 3, 0, 4);
    endtask

    task automatic test_back_to_back();
        int rdy_low, pulses8;
        rdy_low = 0; pulses8 = 0;
        note_period = 16'd2; note_dur = 24'd6; note_valid = 1'b1; stop = 1'b0;
        for (int c = 0; c < 32; c++) begin
            if (c >= 1) begin
                note_period = 16'd3; note_dur = 24'd4; note_valid = (c <= 15);
            end
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (dut_out(i) !== exp_out(i)) begin
                    errors++;
                    $display("FAIL b2b dut%0d c%0d: got %b want %b", i, c, dut_out(i), exp_out(i));
                end
            end
            if (c >= 1 && c <= 15 && note_ready[1] === 1'b0) rdy_low++;
            if (c >= 1 && c <= 14 && sin_clk[1] === 1'b1) pulses8++;
            if (c == 16) begin
                checks++;
                if (playing[1] !== 1'b1) begin errors++; $display("FAIL b2b_second_accept: got playing=%b want 1", playing[1]); end
            end
            clk_step();
        end
        note_valid = 1'b0;
        checks++;
        if (rdy_low != 14) begin errors++; $display("FAIL b2b_ready_low: got %0d want 14", rdy_low); end
        checks++;
        if (pulses8 != 3) begin errors++; $display("FAIL b2b_pulses: got %0d want 3", pulses8); end
    endtask

    task automatic test_stop();
        int dones;
        dones = 0;
        note_period = 16'd5; note_dur = 24'd100; note_valid = 1'b1;
        for (int c = 0; c < 16; c++) begin
            stop = (c == 10);
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (dut_out(i) !== exp_out(i)) begin
                    errors++;
                    $display("FAIL stop dut%0d c%0d: got %b want %b", i, c, dut_out(i), exp_out(i));
                end
            end
            if (c == 10) begin
                checks++;
                if (sin_clk !== 2'b00) begin errors++; $display("FAIL stop_tick: got %b want 00", sin_clk); end
            end
            if (c == 11) begin
                checks++;
                if (playing !== 2'b00) begin errors++; $display("FAIL stop_idle: got %b want 00", playing); end
            end
            if (c > 10 && note_done !== 2'b00) dones++;
            clk_step();
            note_valid = 1'b0;
        end
        stop = 1'b0;
        checks++;
        if (dones != 0) begin errors++; $display("FAIL stop_no_done: got %0d want 0", dones); end
    endtask

    task automatic test_async_reset();
        int first;
        first = -1;
        note_period = 16'd3; note_dur = 24'd50; note_valid = 1'b1; stop = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (dut_out(i) !== exp_out(i)) begin
                    errors++;
                    $display("FAIL areset_pre dut%0d c%0d: got %b want %b", i, c, dut_out(i), exp_out(i));
                end
            end
            clk_step();
            note_valid = 1'b0;
        end
        #1;
        checks++;
        if (sin_clk !== 2'b11) begin errors++; $display("FAIL areset_tick_before: got %b want 11", sin_clk); end
        reset = 1'b0;
        #1;
        model_reset();
        checks++;
        if ({sin_clk, playing} !== 4'b0000) begin
            errors++; $display("FAIL areset_drop: got sin/play=%b want 0000", {sin_clk, playing});
        end
        checks++;
        if (note_ready !== 2'b11) begin errors++; $display("FAIL areset_ready: got %b want 11", note_ready); end
        @(negedge clk);
        reset = 1'b1;
        clk_step();
        note_period = 16'd3; note_dur = 24'd7; note_valid = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (dut_out(i) !== exp_out(i)) begin
                    errors++;
                    $display("FAIL areset_post dut%0d c%0d: got %b want %b", i, c, dut_out(i), exp_out(i));
                end
            end
            if (first < 0 && sin_clk[0] === 1'b1) first = c;
            clk_step();
            note_valid = 1'b0;
        end
        checks++;
        if (first != 3) begin errors++; $display("FAIL areset_fresh_count: got first pulse %0d want 3", first); end
    endtask

    task automatic test_random();
        for (int c = 0; c < 660; c++) begin
            if (c < 600) begin
                note_valid  = ($urandom_range(0, 3) == 0);
                note_period = PW'($urandom_range(0, 5));
                note_dur    = DW'($urandom_range(0, 20));
                stop        = ($urandom_range(0, 29) == 0);
            end else begin
                note_valid = 1'b0; stop = 1'b0;
            end
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (dut_out(i) !== exp_out(i)) begin
                    errors++;
                    $display("FAIL random dut%0d c%0d: got %b want %b", i, c, dut_out(i), exp_out(i));
                end
            end
            clk_step();
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_edges();
        test_stop();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation exceeded time limit");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/tone_tick_gen.md
Name: tone_tick_gen

Overview:
- Upstream stage of the sine wavetable generator. It turns note commands (period, duration) into the single-cycle `sin_clk` step pulses that advance the 256-entry wavetable counter.
- Output tone frequency = f_clk / (256 × period).
- Notes arrive over a valid/ready handshake from the sequencer/ROM player.
- Each note plays for a fixed clock count, then an optional silent articulation gap.

Parameters:
- PERIOD_W, 16, width of note_period (clocks between sin_clk pulses).
- DUR_W, 24, width of note_dur (note length in clocks).
- GAP_CYC, 1024, silent clocks inserted after every note; 0 = no gap.

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted); deassertion is synchronised externally.
- note_valid  input  1  note command valid.
- note_ready  output  1  block can accept a note this cycle.
- note_period  input  PERIOD_W  clocks per sin_clk pulse; 0 = rest (no pulses).
- note_dur  input  DUR_W  note length in clocks; 0 = skip.
- stop  input  1  synchronous abort of the current note/gap.
- sin_clk  output  1  one-clock step pulse to the sine stage.
- playing  output  1  high while in PLAY.
- note_done  output  1  one-clock pulse on the return to IDLE.

Behaviour:
- Reset values (reset=0, asynchronous): state=IDLE, all counters 0, sin_clk=0, playing=0, note_done=0, note_ready=1.
- States: IDLE, PLAY, GAP. All outputs are registered.
- IDLE:
  - note_ready=1.
  - On note_valid&&note_ready, latch period_r and dur_r.
  - If note_dur=0: stay in IDLE and pulse note_done next cycle.
  - Otherwise: next state PLAY, period counter=0, duration counter=note_dur.
  - Inputs are ignored when no handshake occurs.
- note_ready=0 in PLAY and GAP. No note is accepted until back in IDLE, so the minimum spacing between notes is 1 IDLE cycle.
- PLAY:
  - playing=1.
  - Period counter increments each clock.
  - When the counter reaches period_r-1: sin_clk=1 that cycle and the counter wraps to 0.
  - The first pulse therefore comes period_r clocks after entering PLAY.
  - period_r=1: sin_clk high every PLAY cycle. period_r=0: no pulses, the note is a rest.
  - Duration counter decrements each clock. On the cycle it equals 1 (the last PLAY cycle), next state is GAP if GAP_CYC>0, else IDLE.
  - PLAY lasts exactly dur_r clocks.
  - The period counter wraps at PERIOD_W bits without a carry-out; no saturation is needed because the compare happens first.
- GAP:
  - sin_clk=0, playing=0.
  - Gap counter runs GAP_CYC clocks, then state goes to IDLE.
- note_done:
  - Asserted for exactly one cycle, the first IDLE cycle after PLAY/GAP.
  - Also asserted in the cycle after a dur=0 accept.
  - Never asserted after stop.
- stop=1 in PLAY or GAP:
  - Next state is IDLE.
  - sin_clk is forced 0 in that same cycle; stop has priority over a coinciding tick or the last-duration cycle.
  - Counters are cleared.
- stop in IDLE has no effect; a coincident note_valid is still accepted.
- Simultaneous last-duration cycle and tick: the pulse is emitted, then the transition is taken.
- Asynchronous reset mid-note: immediate return to reset values; the latched note is discarded.
- Pulse count per note = floor(dur_r / period_r) for period_r≥1.

Test Plan:
- Reset: hold reset=0 for 5 clocks with note_valid=1 -> sin_clk=0, playing=0, note_ready=1, no accept. Release -> IDLE.
- Basic note (GAP_CYC=0): period=4, dur=20 -> PLAY 20 clocks, 5 pulses on cycles 4,8,12,16,20, note_done one cycle after the last PLAY cycle.
- Gap and backpressure (GAP_CYC=8): note period=2, dur=6, then note_valid held high with a second note -> 3 pulses, 8 silent GAP clocks, note_ready=0 throughout. Second note accepted on the first IDLE cycle.
- Edge values: period=1, dur=3 -> sin_clk high 3 consecutive cycles. period=0, dur=10 -> 10 PLAY cycles, zero pulses. dur=0 -> no PLAY, note_done pulse, ready stays 1.
- Stop priority: period=5, dur=100, stop asserted on cycle 10 (a tick cycle) -> no pulse that cycle, IDLE next cycle, no note_done.
- Async reset mid-PLAY: reset=0 between clock edges -> playing and sin_clk drop to 0 immediately. After release, a new note starts with a fresh period count.
